// File: rtl/conv_encoder_tx_if.sv
// Frame-side handshake and code-symbol bundle of the rate-1/2 K=7 convolutional encoder.
// The encoder uses the slave view; the frame source and symbol sink use the master view.
interface conv_encoder_tx_if;
  logic       start;
  logic       data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] code;
  logic       code_valid;
  logic       first_sym;
  logic       last_sym;
  logic       busy;
  logic       frame_done;

  modport master (
    output start, data_in, data_valid,
    input  data_ready, code, code_valid, first_sym, last_sym, busy, frame_done
  );

  modport slave (
    input  start, data_in, data_valid,
    output data_ready, code, code_valid, first_sym, last_sym, busy, frame_done
  );
endinterface

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder with frame sequencing. Each frame encodes FRAME_LEN payload
// bits, then CONSTRAINT-1 zero tail bits, so the trellis always terminates in state 0.
module conv_encoder_tx #(
  parameter int                    CONSTRAINT = 7,
  parameter logic [CONSTRAINT-1:0] G0         = 7'b1111001,
  parameter logic [CONSTRAINT-1:0] G1         = 7'b1011011,
  parameter int                    FRAME_LEN  = 64
) (
  input logic              clk,
  input logic              rst_n,
  conv_encoder_tx_if.slave bus
);

  localparam int         SR_W      = CONSTRAINT - 1;
  localparam logic [7:0] LAST_DATA = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_TAIL = 8'(CONSTRAINT - 2);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

  state_t                state;
  logic [SR_W-1:0]       sr;
  logic [7:0]            bit_cnt;
  logic                  encode;
  logic                  enc_bit;
  logic [CONSTRAINT-1:0] window;

  // data_ready is a registered copy of (state == DATA), so an accept is just data_valid in DATA.
  always_comb begin
    encode  = 1'b0;
    enc_bit = 1'b0;
    case (state)
      DATA:    begin encode = bus.data_valid; enc_bit = bus.data_in; end
      TAIL:    encode = 1'b1;
      default: ;
    endcase
    window = {enc_bit, sr};
  end

  // NOTE: every register below uses <= so all of them see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sr             <= '0;
      bit_cnt        <= '0;
      bus.code       <= 2'b00;
      bus.code_valid <= 1'b0;
      bus.first_sym  <= 1'b0;
      bus.last_sym   <= 1'b0;
      bus.data_ready <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.code_valid <= encode;
      bus.first_sym  <= 1'b0;
      bus.last_sym   <= 1'b0;
      bus.frame_done <= 1'b0;

      if (encode) begin
        bus.code <= {^(window & G0), ^(window & G1)};
        sr       <= window[CONSTRAINT-1:1];
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= DATA;
            sr             <= '0;
            bit_cnt        <= '0;
            bus.data_ready <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        DATA: begin
          if (bus.data_valid) begin
            bus.first_sym <= (bit_cnt == 8'd0);
            if (bit_cnt == LAST_DATA) begin
              state          <= TAIL;
              bit_cnt        <= '0;
              bus.data_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end
        TAIL: begin
          if (bit_cnt == LAST_TAIL) begin
            state        <= DONE;
            bit_cnt      <= '0;
            bus.last_sym <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        DONE: begin
          // First DONE cycle shows the last symbol; the second carries the frame_done pulse.
          if (!bus.frame_done) begin
            bus.frame_done <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx: a tap-list reference encoder pushes expected symbols
// as bits are accepted; a negedge monitor pops and compares every emitted symbol.
module tb_conv_encoder_tx;
  localparam int K    = 7;
  localparam int FL   = 64;
  localparam int NSYM = FL + K - 1;

  typedef struct packed {
    logic [1:0] code;
    logic       first;
    logic       last;
  } sym_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  conv_encoder_tx_if bus ();

  conv_encoder_tx #(
    .CONSTRAINT (K),
    .G0         (7'b1111001),
    .G1         (7'b1011011),
    .FRAME_LEN  (FL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  sym_t       exp_q[$];
  logic [1:0] got[$];
  logic [5:0] hist;        // hist[0] = previous bit, hist[5] = bit six steps back
  logic       done_due = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_code(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference encoder written as explicit tap lists (171 / 133 octal).
  function automatic void model_push(input logic b, input logic first, input logic last);
    sym_t s;
    s.code[1] = b ^ hist[0] ^ hist[1] ^ hist[2] ^ hist[5];
    s.code[0] = b ^ hist[1] ^ hist[2] ^ hist[4] ^ hist[5];
    s.first   = first;
    s.last    = last;
    hist      = {hist[4:0], b};
    exp_q.push_back(s);
  endfunction

  function automatic void reset_model();
    hist = '0;
    exp_q.delete();
    got.delete();
  endfunction

  always @(negedge clk) begin : monitor
    sym_t s;
    if (rst_n) begin
      if (done_due || bus.frame_done) check("frame_done", bus.frame_done, done_due);
      done_due = 1'b0;
      if (exp_q.size() == 0) begin
        if (bus.code_valid) check("spurious_code_valid", bus.code_valid, 1'b0);
      end else if (bus.code_valid) begin
        s = exp_q.pop_front();
        check_code("code", bus.code, s.code);
        check("first_sym", bus.first_sym, s.first);
        check("last_sym", bus.last_sym, s.last);
        got.push_back(bus.code);
        if (s.last) done_due = 1'b1;
      end
    end
  end

  task automatic start_frame(input logic hold);
    reset_model();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    check("ready_after_start", bus.data_ready, 1'b1);
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  // mode 0: always valid, 1: valid toggles, 2: random valid with random start pulses
  task automatic send_payload(input logic [FL-1:0] p, input int n, input int mode);
    int   i   = 0;
    int   cyc = 0;
    logic v;
    while (i < n && cyc < 1000) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) bus.start = 1'($urandom_range(0, 1));
      if (mode == 1 && !v) check("ready_in_stall", bus.data_ready, 1'b1);
      bus.data_valid = v;
      bus.data_in    = v ? p[i] : 1'($urandom_range(0, 1));
      if (v && bus.data_ready) begin
        model_push(p[i], i == 0, 1'b0);
        i++;
        if (i == FL)
          for (int t = 0; t < K - 1; t++) model_push(1'b0, 1'b0, t == K - 2);
      end
      cyc++;
    end
    check_int("payload_accepts", i, n);
    if (mode == 2) bus.start = 1'b0;
    if (n == FL) begin
      @(negedge clk);
      bus.data_valid = 1'b1;   // must be ignored during the tail
      bus.data_in    = 1'b1;
      check("ready_drop_after_last", bus.data_ready, 1'b0);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!bus.frame_done && cyc < 200) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      cyc++;
    end
    check("frame_done_seen", bus.frame_done, 1'b1);
    check_int("queue_drained", exp_q.size(), 0);
    check_int("symbol_count", got.size(), NSYM);
    @(negedge clk);
    check("busy_after_done", bus.busy, 1'b0);
    check("ready_idle_gap", bus.data_ready, 1'b0);
  endtask

  task automatic check_impulse();
    logic [1:0] imp [7];
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    for (int j = 0; j < got.size(); j++)
      check_code("impulse_sym", got[j], (j < 7) ? imp[j] : 2'b00);
  endtask

  initial begin
    logic [FL-1:0] impulse;
    impulse        = '0;
    impulse[0]     = 1'b1;
    bus.start      = 1'b0;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    hist           = '0;

    repeat (3) @(negedge clk);
    check_code("reset_code", bus.code, 2'b00);
    check("reset_code_valid", bus.code_valid, 1'b0);
    check("reset_ready", bus.data_ready, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_first", bus.first_sym, 1'b0);
    check("reset_last", bus.last_sym, 1'b0);
    check("reset_done", bus.frame_done, 1'b0);
    rst_n = 1'b1;

    // Impulse
    start_frame(1'b0);
    send_payload(impulse, FL, 0);
    wait_done();
    check_impulse();

    // Stalls: identical symbols, ready held through gaps
    start_frame(1'b0);
    send_payload(impulse, FL, 1);
    wait_done();
    check_impulse();

    // All ones
    start_frame(1'b0);
    send_payload({FL{1'b1}}, FL, 0);
    wait_done();
    if (got.size() > 10) check_code("steady_ones", got[10], 2'b11);

    // Reset abort after 10 accepts
    start_frame(1'b0);
    send_payload(impulse, 10, 0);
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_int("abort_symbols", got.size(), 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_code("abort_code", bus.code, 2'b00);
    check("abort_ready", bus.data_ready, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_first", bus.first_sym, 1'b0);
    check("abort_done", bus.frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_idle_busy", bus.busy, 1'b0);
    start_frame(1'b0);
    send_payload(impulse, FL, 0);
    wait_done();
    check_impulse();

    // Start held high: restart only from IDLE, one idle cycle after frame_done
    start_frame(1'b1);
    send_payload({$urandom, $urandom}, FL, 0);
    wait_done();
    reset_model();
    @(negedge clk);
    check("restart_ready", bus.data_ready, 1'b1);
    bus.start = 1'b0;
    send_payload(impulse, FL, 0);
    wait_done();
    check_impulse();

    // Random frames with random valid and stray start pulses
    for (int f = 0; f < 100; f++) begin
      start_frame(1'b0);
      send_payload({$urandom, $urandom}, FL, 2);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
